// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, default polynomial
// and the next-bit prediction used by both the data generator and the checker.
package prbs_pkg;

   localparam int PRBS_DEFAULT_LENGTH = 9;
   localparam int PRBS_DEFAULT_TAP    = 5;
   localparam int MAX_POLY_LENGTH     = 32;
   localparam int STATE_W             = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_FILL   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } prbs_state_t;

   // Next PRBS bit for x^poly_length + x^poly_tap + 1, given the history
   // register with the newest bit in position 0.
   function automatic logic prbs_predict(input logic [MAX_POLY_LENGTH-1:0] sr,
                                         input int poly_length,
                                         input int poly_tap);
      logic [MAX_POLY_LENGTH-1:0] far_bit;
      logic [MAX_POLY_LENGTH-1:0] tap_bit;
      far_bit = sr >> (poly_length - 1);
      tap_bit = sr >> (poly_tap - 1);
      return far_bit[0] ^ tap_bit[0];
   endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Serial input and status read-out bundle between the serialiser side
// and the PRBS checker.
interface prbs_checker_if #(
   parameter int CNT_WIDTH = 32
);
   import prbs_pkg::*;

   logic                 bit_in;
   logic                 bit_valid;
   logic                 clear_counters;
   logic                 locked;
   logic                 err_pulse;
   logic [STATE_W-1:0]   state;
   logic [CNT_WIDTH-1:0] bit_count;
   logic [CNT_WIDTH-1:0] err_count;

   modport master (
      output bit_in, bit_valid, clear_counters,
      input  locked, err_pulse, state, bit_count, err_count
   );

   modport slave (
      input  bit_in, bit_valid, clear_counters,
      output locked, err_pulse, state, bit_count, err_count
   );

endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with a clear that wins over a same-cycle increment.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count up on inc, hold at all-ones, zero on reset or clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: fills its history register,
// hunts for a run of correct predictions, then counts bits and errors
// while locked and drops lock when a window collects too many errors.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int POLY_LENGTH = PRBS_DEFAULT_LENGTH,
   parameter int POLY_TAP    = PRBS_DEFAULT_TAP,
   parameter bit INV_PATTERN = 1'b1,
   parameter int LOCK_COUNT  = 32,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_WIDTH   = 32
) (
   input logic           clk,
   input logic           rst,
   prbs_checker_if.slave bus
);

   localparam int FILL_W = $clog2(POLY_LENGTH + 1);
   localparam int HUNT_W = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W  = $clog2(WINDOW + 1);
   localparam int WERR_W = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(POLY_LENGTH - 1);
   localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(LOCK_COUNT - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THRESH - 1);

   prbs_state_t            state_q, state_d;
   logic [POLY_LENGTH-1:0] sr_q, sr_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic [HUNT_W-1:0]      hunt_q, hunt_d;
   logic [WIN_W-1:0]       win_q, win_d;
   logic [WERR_W-1:0]      werr_q, werr_d;
   logic                   locked_q, locked_d;
   logic                   err_pulse_q, err_pulse_d;

   logic bit_r;
   logic predicted;
   logic mismatch;
   logic count_bit;
   logic count_err;

   assign bit_r     = bus.bit_in ^ INV_PATTERN;
   assign predicted = prbs_predict(MAX_POLY_LENGTH'(sr_q), POLY_LENGTH, POLY_TAP);
   assign mismatch  = (bit_r != predicted);

   // Next-state, history shift and hunt/window bookkeeping for each valid bit.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      hunt_d      = hunt_q;
      win_d       = win_q;
      werr_d      = werr_q;
      err_pulse_d = 1'b0;
      count_bit   = 1'b0;
      count_err   = 1'b0;

      if (bus.bit_valid) begin
         sr_d = {sr_q[POLY_LENGTH-2:0], bit_r};
         case (state_q)
            ST_FILL: begin
               if (fill_q == FILL_LAST) begin
                  state_d = ST_HUNT;
                  fill_d  = '0;
                  hunt_d  = '0;
               end else begin
                  fill_d = fill_q + FILL_W'(1);
               end
            end
            ST_HUNT: begin
               if (mismatch) begin
                  hunt_d = '0;
               end else if (hunt_q == HUNT_LAST) begin
                  state_d = ST_LOCKED;
                  hunt_d  = '0;
                  win_d   = '0;
                  werr_d  = '0;
               end else begin
                  hunt_d = hunt_q + HUNT_W'(1);
               end
            end
            ST_LOCKED: begin
               count_bit = 1'b1;
               if (mismatch) begin
                  count_err   = 1'b1;
                  err_pulse_d = 1'b1;
               end
               if (mismatch && (werr_q == WERR_LAST)) begin
                  state_d = ST_FILL;
                  fill_d  = '0;
                  hunt_d  = '0;
                  win_d   = '0;
                  werr_d  = '0;
               end else if (win_q == WIN_LAST) begin
                  win_d  = '0;
                  werr_d = '0;
               end else begin
                  win_d = win_q + WIN_W'(1);
                  if (mismatch) begin
                     werr_d = werr_q + WERR_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_FILL;
               fill_d  = '0;
               hunt_d  = '0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State, history and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FILL;
         sr_q        <= '0;
         fill_q      <= '0;
         hunt_q      <= '0;
         win_q       <= '0;
         werr_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         hunt_q      <= hunt_d;
         win_q       <= win_d;
         werr_q      <= werr_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clear_counters),
      .inc   (count_bit),
      .count (bus.bit_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_err_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clear_counters),
      .inc   (count_err),
      .count (bus.err_count)
   );

   assign bus.state     = state_q;
   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: a phase table with hand-derived
// end-of-phase values, directed clear/error sequences and a randomized
// run, all shadowed cycle by cycle by a behavioural reference model.
module tb_prbs_checker;

   logic clk;
   logic rst;

   prbs_checker_if #(.CNT_WIDTH(32)) bus ();
   prbs_checker_if #(.CNT_WIDTH(4))  sat_bus ();

   assign sat_bus.bit_in         = bus.bit_in;
   assign sat_bus.bit_valid      = bus.bit_valid;
   assign sat_bus.clear_counters = bus.clear_counters;

   prbs_checker #(.CNT_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   prbs_checker #(.CNT_WIDTH(4)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sat_bus)
   );

   // 100 MHz bit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Transmit-side PRBS9 history (oldest first) and reference model state.
   bit     gen_q[$];
   bit     m_hist[$];
   int     m_mode;
   int     m_fill;
   int     m_run;
   int     m_since_lock;
   int     m_win_errs;
   bit     m_pulse;
   longint m_bits;
   longint m_errs;
   longint m_sat_bits;
   longint m_sat_errs;

   task automatic check_val(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < 9; i++) m_hist.push_back(1'b0);
      m_mode = 0; m_fill = 0; m_run = 0; m_since_lock = 0; m_win_errs = 0;
      m_pulse = 1'b0;
      m_bits = 0; m_errs = 0; m_sat_bits = 0; m_sat_errs = 0;
   endtask

   // Reference behaviour for one clock: prediction from the bits received
   // 9 and 5 valid bits ago, then fill / hunt / locked bookkeeping.
   task automatic model_step(input bit valid, input bit b, input bit clr);
      bit r;
      bit wrong;
      bit cnt_b;
      bit cnt_e;
      cnt_b   = 1'b0;
      cnt_e   = 1'b0;
      m_pulse = 1'b0;
      if (valid) begin
         r     = b ^ 1'b1;
         wrong = (r != (m_hist[0] ^ m_hist[4]));
         if (m_mode == 0) begin
            m_fill++;
            if (m_fill == 9) begin
               m_mode = 1;
               m_run  = 0;
            end
         end else if (m_mode == 1) begin
            if (wrong) m_run = 0;
            else begin
               m_run++;
               if (m_run == 32) begin
                  m_mode = 2;
                  m_since_lock = 0;
                  m_win_errs = 0;
               end
            end
         end else begin
            cnt_b = 1'b1;
            m_since_lock++;
            if (wrong) begin
               cnt_e   = 1'b1;
               m_pulse = 1'b1;
               m_win_errs++;
            end
            if (m_win_errs == 8) begin
               m_mode = 0;
               m_fill = 0;
               m_run  = 0;
            end else if (m_since_lock % 64 == 0) begin
               m_win_errs = 0;
            end
         end
         m_hist.push_back(r);
         void'(m_hist.pop_front());
      end
      if (clr) begin
         m_bits = 0; m_errs = 0; m_sat_bits = 0; m_sat_errs = 0;
      end else begin
         if (cnt_b && m_bits < 64'hFFFF_FFFF) m_bits++;
         if (cnt_e && m_errs < 64'hFFFF_FFFF) m_errs++;
         if (cnt_b && m_sat_bits < 15) m_sat_bits++;
         if (cnt_e && m_sat_errs < 15) m_sat_errs++;
      end
   endtask

   task automatic check_output();
      check_val("state",        longint'(bus.state),         longint'(m_mode));
      check_val("locked",       longint'(bus.locked),        longint'(m_mode == 2));
      check_val("err_pulse",    longint'(bus.err_pulse),     longint'(m_pulse));
      check_val("bit_count",    longint'(bus.bit_count),     m_bits);
      check_val("err_count",    longint'(bus.err_count),     m_errs);
      check_val("sat_bit_count", longint'(sat_bus.bit_count), m_sat_bits);
      check_val("sat_err_count", longint'(sat_bus.err_count), m_sat_errs);
   endtask

   // One clock of stimulus; a valid bit advances the inverted PRBS9 source.
   task automatic apply_stimulus(input bit valid, input bit flip, input bit clr);
      bit g;
      bit tx;
      tx = 1'($urandom_range(0, 1));
      if (valid) begin
         g = gen_q[0] ^ gen_q[4];
         gen_q.push_back(g);
         void'(gen_q.pop_front());
         tx = g ^ 1'b1 ^ flip;
      end
      bus.bit_in         = tx;
      bus.bit_valid      = valid;
      bus.clear_counters = clr;
      model_step(valid, tx, clr);
      @(posedge clk);
      #1;
      check_output();
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.bit_valid      = 1'b1;
      bus.bit_in         = 1'b1;
      bus.clear_counters = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      check_output();
      rst           = 1'b0;
      bus.bit_valid = 1'b0;
   endtask

   typedef struct {
      bit do_rst;
      int n_valid;
      bit alt;
      int flip_a;
      int flip_b;
      int flip_c;
      bit exp_locked;
      int exp_state;
      int exp_bits;
      int exp_errs;
      int exp_sat_bits;
   } vec_t;

   vec_t vecs[9];
   int   pulse_idx[$];
   bit   v;
   bit   f;
   bit   c;

   initial begin
      rst                = 1'b1;
      bus.bit_in         = 1'b0;
      bus.bit_valid      = 1'b0;
      bus.clear_counters = 1'b0;
      gen_q.delete();
      for (int i = 0; i < 9; i++) gen_q.push_back(i == 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_output();
      rst = 1'b0;

      vecs[0] = '{1'b1, 40,   1'b0, -1, -1, -1, 1'b0, 1, 0,    0,  0};
      vecs[1] = '{1'b0, 1,    1'b0, -1, -1, -1, 1'b1, 2, 0,    0,  0};
      vecs[2] = '{1'b0, 1000, 1'b0, -1, -1, -1, 1'b1, 2, 1000, 0,  15};
      vecs[3] = '{1'b0, 20,   1'b0,  0, -1, -1, 1'b1, 2, 1020, 3,  15};
      vecs[4] = '{1'b0, 30,   1'b0,  0, 10, 20, 1'b0, 0, 1050, 12, 15};
      vecs[5] = '{1'b0, 41,   1'b0, -1, -1, -1, 1'b1, 2, 1050, 12, 15};
      vecs[6] = '{1'b1, 40,   1'b1, -1, -1, -1, 1'b0, 1, 0,    0,  0};
      vecs[7] = '{1'b0, 1,    1'b1, -1, -1, -1, 1'b1, 2, 0,    0,  0};
      vecs[8] = '{1'b0, 100,  1'b1, -1, -1, -1, 1'b1, 2, 100,  0,  15};

      for (int r = 0; r < 9; r++) begin
         if (vecs[r].do_rst) do_reset();
         for (int i = 0; i < vecs[r].n_valid; i++) begin
            if (vecs[r].alt) apply_stimulus(1'b0, 1'b0, 1'b0);
            f = (i == vecs[r].flip_a) || (i == vecs[r].flip_b) || (i == vecs[r].flip_c);
            apply_stimulus(1'b1, f, 1'b0);
         end
         check_val($sformatf("row%0d_locked", r), longint'(bus.locked),  longint'(vecs[r].exp_locked));
         check_val($sformatf("row%0d_state", r),  longint'(bus.state),   longint'(vecs[r].exp_state));
         check_val($sformatf("row%0d_bits", r),   longint'(bus.bit_count), longint'(vecs[r].exp_bits));
         check_val($sformatf("row%0d_errs", r),   longint'(bus.err_count), longint'(vecs[r].exp_errs));
         check_val($sformatf("row%0d_sat_bits", r), longint'(sat_bus.bit_count), longint'(vecs[r].exp_sat_bits));
      end

      // Clear on the same cycle as a line error, then watch the echoes.
      pulse_idx.delete();
      apply_stimulus(1'b1, 1'b1, 1'b1);
      check_val("clr_bits",   longint'(bus.bit_count), 0);
      check_val("clr_errs",   longint'(bus.err_count), 0);
      check_val("clr_locked", longint'(bus.locked),    1);
      if (bus.err_pulse) pulse_idx.push_back(0);
      for (int k = 1; k <= 12; k++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0);
         if (bus.err_pulse) pulse_idx.push_back(k);
      end
      check_val("echo_pulses", longint'(pulse_idx.size()), 3);
      check_val("echo_pos0", longint'(pulse_idx.size() > 0 ? pulse_idx[0] : -1), 0);
      check_val("echo_pos1", longint'(pulse_idx.size() > 1 ? pulse_idx[1] : -1), 5);
      check_val("echo_pos2", longint'(pulse_idx.size() > 2 ? pulse_idx[2] : -1), 9);
      check_val("echo_errs",   longint'(bus.err_count), 2);
      check_val("echo_bits",   longint'(bus.bit_count), 12);
      check_val("echo_locked", longint'(bus.locked),    1);

      // Randomized traffic: sparse errors, then a dense burst, with a reset between.
      for (int n = 0; n < 2500; n++) begin
         v = ($urandom_range(0, 9) < 7);
         f = v && ($urandom_range(0, 199) == 0);
         c = ($urandom_range(0, 399) == 0);
         apply_stimulus(v, f, c);
      end
      do_reset();
      for (int n = 0; n < 2500; n++) begin
         v = ($urandom_range(0, 9) < 8);
         f = v && ($urandom_range(0, 99) < ((n % 500) < 250 ? 1 : 6));
         c = ($urandom_range(0, 499) == 0);
         apply_stimulus(v, f, c);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
